// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter (5-9 data bits, optional even/odd parity, 1-2 stop bits)
module uart_tx_param #(
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [3:0]        bcnt;
  logic [DATA_W-1:0] shreg;
  logic              par;
  logic              last;
  assign last     = cnt == CW'(CLKS_PER_BIT - 1);
  assign tx_ready = state == IDLE;
  assign busy     = ~tx_ready;
  // Frame sequencer: baud counter restarts at every bit boundary; done is raised one cycle early so it lands on the final terminal count
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      tx    <= 1'b1;
      done  <= 1'b0;
      cnt   <= '0;
      bcnt  <= '0;
      shreg <= '0;
      par   <= 1'b0;
    end else begin
      done <= state == STOP && bcnt == 4'(STOP_BITS - 1) && cnt == CW'(CLKS_PER_BIT - 2);
      cnt  <= (state == IDLE || last) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (tx_valid) begin
          state <= START;
          tx    <= 1'b0;
          shreg <= tx_data;
          par   <= ^tx_data ^ 1'(PARITY_ODD);
          bcnt  <= '0;
        end
        START: if (last) begin
          state <= DATA;
          tx    <= shreg[0];
          shreg <= shreg >> 1;
        end
        DATA: if (last) begin
          if (bcnt == 4'(DATA_W - 1)) begin
            bcnt  <= '0;
            state <= PARITY_EN != 0 ? PARITY : STOP;
            tx    <= PARITY_EN != 0 ? par : 1'b1;
          end else begin
            bcnt  <= bcnt + 1'b1;
            tx    <= shreg[0];
            shreg <= shreg >> 1;
          end
        end
        PARITY: if (last) begin
          state <= STOP;
          tx    <= 1'b1;
        end
        STOP: if (last) begin
          if (bcnt == 4'(STOP_BITS - 1)) begin
            state <= IDLE;
            bcnt  <= '0;
          end else
            bcnt <= bcnt + 1'b1;
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed checks of frame shape, parity, stop bits, back-to-back and reset behaviour
module tb_uart_tx_param;
  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [8:0] dat [4];
  logic       vld [4];
  logic       rdy [4];
  logic       txo [4];
  logic       bsy [4];
  logic       dn  [4];
  int         checks = 0;
  int         errors = 0;
  always #5 clk = ~clk;
  uart_tx_param #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .CLKS_PER_BIT(4)) u_a (
    .clk(clk), .nrst(nrst), .tx_data(dat[0][7:0]), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]), .done(dn[0]));
  uart_tx_param #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .CLKS_PER_BIT(4)) u_b (
    .clk(clk), .nrst(nrst), .tx_data(dat[1][7:0]), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]), .done(dn[1]));
  uart_tx_param #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2), .CLKS_PER_BIT(4)) u_c (
    .clk(clk), .nrst(nrst), .tx_data(dat[2][7:0]), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]), .done(dn[2]));
  uart_tx_param #(.DATA_W(5), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .CLKS_PER_BIT(2)) u_d (
    .clk(clk), .nrst(nrst), .tx_data(dat[3][4:0]), .tx_valid(vld[3]),
    .tx_ready(rdy[3]), .tx(txo[3]), .busy(bsy[3]), .done(dn[3]));

  // bits holds the frame as {stop.., parity, data MSB..LSB, start}; bit 0 goes out first
  task automatic send(input int k, input logic [8:0] d, input logic [8:0] nxt, input logic keep,
                      input logic [15:0] bits, input int nb, input int cpb, input string nm);
    int n;
    logic [3:0] exp, got;
    dat[k] = d;
    vld[k] = 1'b1;
    n = 0;
    while (!rdy[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rdy[k]) begin
      errors++;
      $display("FAIL %s ready_timeout got rdy=%b want 1", nm, rdy[k]);
    end
    @(posedge clk);
    #1;
    dat[k] = nxt;
    vld[k] = keep;
    for (int i = 0; i < nb; i++)
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        exp = {bits[i], (i == nb - 1 && c == cpb - 1), 1'b0, 1'b1};
        got = {txo[k], dn[k], rdy[k], bsy[k]};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL %s bit%0d cyc%0d {tx,done,ready,busy} got %b want %b", nm, i, c, got, exp);
        end
      end
    @(negedge clk);
    got = {txo[k], dn[k], rdy[k], bsy[k]};
    checks++;
    if (got !== 4'b1010) begin
      errors++;
      $display("FAIL %s idle_after {tx,done,ready,busy} got %b want 1010", nm, got);
    end
  endtask

  task automatic test_reset();
    logic [3:0] got;
    nrst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vld[k] = 1'b0;
      dat[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      got = {txo[k], dn[k], rdy[k], bsy[k]};
      checks++;
      if (got !== 4'b1010) begin
        errors++;
        $display("FAIL reset_state inst%0d {tx,done,ready,busy} got %b want 1010", k, got);
      end
    end
    vld[0] = 1'b1;
    dat[0] = 9'h0FF;
    @(posedge clk);
    @(negedge clk);
    got = {txo[0], dn[0], rdy[0], bsy[0]};
    checks++;
    if (got !== 4'b1010) begin
      errors++;
      $display("FAIL reset_priority {tx,done,ready,busy} got %b want 1010", got);
    end
    vld[0] = 1'b0;
    nrst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    send(0, 9'h0A5, 9'h05A, 1'b0, 16'b1_0_10100101_0, 11, 4, "basic_a5");
  endtask

  task automatic test_odd_parity();
    send(1, 9'h007, 9'h0F8, 1'b0, 16'b1_0_00000111_0, 11, 4, "odd_07");
    send(1, 9'h003, 9'h0FC, 1'b0, 16'b1_1_00000011_0, 11, 4, "odd_03");
  endtask

  task automatic test_two_stop();
    send(2, 9'h000, 9'h0FF, 1'b0, 16'b11_00000000_0, 11, 4, "stop2_00");
  endtask

  task automatic test_back_to_back();
    send(0, 9'h03C, 9'h0C3, 1'b1, 16'b1_0_00111100_0, 11, 4, "b2b_3c");
    send(0, 9'h0C3, 9'h080, 1'b1, 16'b1_0_11000011_0, 11, 4, "b2b_c3");
    send(0, 9'h080, 9'h07F, 1'b0, 16'b1_1_10000000_0, 11, 4, "b2b_80");
  endtask

  task automatic test_reset_mid();
    logic [3:0] got;
    @(posedge clk);
    #1;
    dat[0] = 9'h05A;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    for (int s = 0; s < 14; s++) begin
      @(negedge clk);
      checks++;
      if (dn[0] !== 1'b0) begin
        errors++;
        $display("FAIL mid_no_done s%0d got done=%b want 0", s, dn[0]);
      end
    end
    checks++;
    if (txo[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_d2 got tx=%b want 0", txo[0]);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({txo[0], bsy[0]} !== 2'b11) begin
      errors++;
      $display("FAIL mid_d3 {tx,busy} got %b want 11", {txo[0], bsy[0]});
    end
    nrst = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      got = {txo[0], dn[0], rdy[0], bsy[0]};
      checks++;
      if (got !== 4'b1010) begin
        errors++;
        $display("FAIL mid_after_reset s%0d {tx,done,ready,busy} got %b want 1010", s, got);
      end
    end
    send(0, 9'h0A5, 9'h05A, 1'b0, 16'b1_0_10100101_0, 11, 4, "post_reset_a5");
  endtask

  task automatic test_narrow();
    send(3, 9'h01F, 9'h000, 1'b0, 16'b1_1_11111_0, 8, 2, "narrow_1f");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_parity();
    test_two_stop();
    test_back_to_back();
    test_reset_mid();
    test_narrow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, meaning data bits per frame (legal 5..9).
REQ-002 The module SHALL have parameter PARITY_EN, default 1, meaning that 1 inserts a parity bit after the data and 0 omits it.
REQ-003 The module SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity and 1 = odd parity (ignored when PARITY_EN=0).
REQ-004 The module SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal 1 or 2).
REQ-005 The module SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit (legal >= 2).
REQ-006 The module SHALL have port clk, input, 1 bit: system clock; all logic rises on its posedge.
REQ-007 The module SHALL have port nrst, input, 1 bit: reset, synchronous, active-low.
REQ-008 The module SHALL have port tx_data, input, DATA_W bits: parallel word to send.
REQ-009 The module SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-010 The module SHALL have port tx_ready, output, 1 bit: the block can accept a word.
REQ-011 The module SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-012 The module SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-013 The module SHALL have port done, output, 1 bit: one-cycle pulse at the end of the frame.

Function
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY and STOP; the state encoding is implementation-defined.
REQ-015 tx_ready SHALL equal (state==IDLE); busy SHALL equal !tx_ready.
REQ-016 A handshake SHALL occur on a posedge where tx_valid && tx_ready; tx_data is then latched into an internal shift register and the state goes to START.
REQ-017 tx_valid while busy SHALL be ignored, and tx_data changes after the handshake SHALL NOT affect the frame in flight.
REQ-018 tx SHALL be registered and SHALL go to 0 on the first posedge after the handshake (latency 1 cycle).
REQ-019 An internal baud counter SHALL count 0..CLKS_PER_BIT-1, clear on every state entry, and end the current bit on its terminal count.
REQ-020 Each bit (start, each data bit, parity, each stop bit) SHALL hold tx for exactly CLKS_PER_BIT cycles.
REQ-021 START SHALL drive tx=0 and then transition to DATA.
REQ-022 DATA SHALL drive data LSB first, advance a bit counter 0..DATA_W-1 at each bit end, and exit after bit DATA_W-1 to PARITY if PARITY_EN, else to STOP.
REQ-023 The parity bit SHALL be XOR of the latched word when even, and its inverse when odd; PARITY then transitions to STOP.
REQ-024 STOP SHALL drive tx=1 for STOP_BITS bit times and then transition to IDLE.
REQ-025 done SHALL be 1 for exactly the single cycle in which the final stop-bit terminal count occurs.
REQ-026 The frame SHALL last (1+DATA_W+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles from the first tx=0 cycle.
REQ-027 The earliest next handshake SHALL be the cycle after the state returns to IDLE, so there is at least 1 idle cycle between frames with tx=1.
REQ-028 The FSM SHALL enter IDLE from any unused state encoding on the next posedge.

Reset
REQ-029 While nrst=0 at a posedge, state SHALL become IDLE, tx=1, done=0, and all counters and the shift register SHALL become 0.
REQ-030 After reset, tx_ready SHALL be 1 and busy 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no done pulse; tx=1 SHALL hold from the next posedge.
REQ-032 Reset SHALL take priority over a simultaneous handshake.

Verification
REQ-033 The bench SHALL run with DATA_W=8, PARITY_EN=1, PARITY_ODD=0, STOP_BITS=1, CLKS_PER_BIT=4, sending 0xA5: tx SHALL be 0 | 1,0,1,0,0,1,0,1 | 0 | 1, each held 4 cycles (44 cycles total), with done pulsed once at cycle 44.
REQ-034 The bench SHALL run with PARITY_ODD=1, sending 0x07: the parity bit SHALL be 0, and with 0x03 it SHALL be 1.
REQ-035 The bench SHALL run with STOP_BITS=2 and PARITY_EN=0, sending 0x00: tx SHALL be low for 36 cycles then high for 8, with tx_ready=0 until the cycle after the last stop cycle.
REQ-036 The bench SHALL hold tx_valid=1 continuously with changing tx_data: each frame SHALL carry the word present at its handshake, and at least 1 idle tx=1 cycle SHALL separate frames.
REQ-037 The bench SHALL assert nrst=0 during data bit 3: the next cycle SHALL show tx=1, tx_ready=1, done never pulsed, and the following frame SHALL be correct.
REQ-038 The bench SHALL run with DATA_W=5 and CLKS_PER_BIT=2, sending 0x1F with even parity: tx SHALL be 0,1,1,1,1,1,1,1, each held 2 cycles (16 cycles).
